// File: rtl/if_id_queue.sv
// if_id_queue: IF/ID stage pairing each ROM response with its PC, buffered in a FIFO toward decode.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   stall[5:0]        bit0 PC, bit1 IF/ID, bit2 ID (1 = stop); bits 5:3 unused here
//   flush             discard everything fetched
//   if_pc, if_ce      PC and ROM chip enable from the PC register
//   rom_rdata         ROM data for the address presented the previous cycle
//   fq_stall          back-pressure into stall[0], combinational from registers only
//   id_pc/id_inst/id_valid  registered triple presented to decode
//   fetch_cnt/bubble_cnt    delivery/bubble counters, built only with IF_ID_QUEUE_STATS_EN (else 0)
module if_id_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        flush,
  input  logic [31:0] if_pc,
  input  logic        if_ce,
  input  logic [31:0] rom_rdata,
  output logic        fq_stall,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  output logic        id_valid,
  output logic [31:0] fetch_cnt,
  output logic [31:0] bubble_cnt
);
  localparam logic [AW:0] full = (AW+1)'(DEPTH);
  logic          inflight_q;
  logic [31:0]   req_pc_q;
  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0]   count;
  logic          req, pop, push, bubble;
  logic          unused;
  assign unused   = ^stall[5:3];
  assign req      = if_ce & ~stall[0] & ~flush;
  assign fq_stall = (count + (AW+1)'(inflight_q)) >= full;
  assign pop      = ~flush & ~stall[1] & (count != '0);
  assign bubble   = ~flush & (stall[1] ? ~stall[2] : (count == '0));
  // a push into a full FIFO is accepted only if the head leaves on the same edge
  assign push     = inflight_q & ~flush & ((count != full) | pop);
  always_ff @(posedge clk)
    if (push & ~rst) mem[wr_ptr] <= {req_pc_q, rom_rdata};
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q <= 1'b0;
      req_pc_q   <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      id_pc      <= '0;
      id_inst    <= '0;
      id_valid   <= 1'b0;
    end else begin
      inflight_q <= req;
      if (req) req_pc_q <= if_pc;
      if (flush) begin
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
        id_pc    <= '0;
        id_inst  <= '0;
        id_valid <= 1'b0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop) begin
          {id_pc, id_inst} <= mem[rd_ptr];
          id_valid         <= 1'b1;
          rd_ptr           <= rd_ptr + 1'b1;
        end else if (bubble) begin
          id_pc    <= '0;
          id_inst  <= '0;
          id_valid <= 1'b0;
        end
        count <= count + (AW+1)'(push) - (AW+1)'(pop);
      end
    end
  end
`ifdef IF_ID_QUEUE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (pop) fetch_cnt <= fetch_cnt + 1'b1;
      if (bubble) bubble_cnt <= bubble_cnt + 1'b1;
    end
  end
`else
  assign fetch_cnt  = '0;
  assign bubble_cnt = '0;
`endif
endmodule

// File: tb/tb_if_id_queue.sv
// tb_if_id_queue: randomized + directed self-checking bench for if_id_queue against a queue-based model.
module tb_if_id_queue;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic rst, flush, if_ce, fq_stall, id_valid;
  logic [5:0] stall;
  logic [31:0] if_pc, rom_rdata, id_pc, id_inst, fetch_cnt, bubble_cnt;
  int errors = 0;
  int checks = 0;
  logic [63:0] q[$];
  logic m_inf, m_val;
  logic [31:0] m_req, m_pc, m_inst, m_fetch, m_bub;
  logic [31:0] last_pc, redir;
  always #5 clk = ~clk;
  if_id_queue #(.DEPTH(DEPTH), .AW(2)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .if_pc(if_pc), .if_ce(if_ce),
    .rom_rdata(rom_rdata), .fq_stall(fq_stall), .id_pc(id_pc), .id_inst(id_inst),
    .id_valid(id_valid), .fetch_cnt(fetch_cnt), .bubble_cnt(bubble_cnt)
  );
  function automatic logic m_fq();
    return (q.size() + int'(m_inf)) >= DEPTH;
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask
  task automatic check_all();
    chk("id_pc", id_pc, m_pc);
    chk("id_inst", id_inst, m_inst);
    chk("id_valid", {31'b0, id_valid}, {31'b0, m_val});
    chk("fq_stall", {31'b0, fq_stall}, {31'b0, m_fq()});
`ifdef IF_ID_QUEUE_STATS_EN
    chk("fetch_cnt", fetch_cnt, m_fetch);
    chk("bubble_cnt", bubble_cnt, m_bub);
`else
    chk("fetch_cnt", fetch_cnt, 32'h0);
    chk("bubble_cnt", bubble_cnt, 32'h0);
`endif
  endtask
  task automatic step(input logic r, input logic f, input logic [5:0] s, input logic ce, input logic bad);
    logic [5:0] se;
    int sz;
    se = s;
    se[0] = s[0] | m_fq();
    rst = r; flush = f; stall = se; if_ce = ce;
    rom_rdata = bad ? 32'hDEADBEEF : 32'h20000000 + last_pc;
    if (r) begin
      q.delete(); m_inf = 0; m_req = 0; m_pc = 0; m_inst = 0; m_val = 0; m_fetch = 0; m_bub = 0;
    end else if (f) begin
      q.delete(); m_inf = 0; m_pc = 0; m_inst = 0; m_val = 0;
    end else begin
      sz = q.size();
      if (se[1] && se[2]) begin
      end else if (!se[1] && sz > 0) begin
        {m_pc, m_inst} = q.pop_front(); m_val = 1; m_fetch++;
      end else begin
        m_pc = 0; m_inst = 0; m_val = 0; m_bub++;
      end
      if (m_inf) begin
        checks++;
        assert (q.size() < DEPTH) else begin
          errors++;
          $error("FAIL no_drop: observed=%0d expected<%0d", q.size(), DEPTH);
        end
        if (q.size() < DEPTH) q.push_back({m_req, rom_rdata});
      end
      m_inf = ce & ~se[0];
      if (m_inf) m_req = if_pc;
    end
    @(posedge clk);
    @(negedge clk);
    check_all();
    last_pc = if_pc;
    if (r) if_pc = 0;
    else if (f) if_pc = redir;
    else if (ce && !se[0]) if_pc = if_pc + 4;
  endtask
  initial begin
    rst = 1; flush = 0; stall = 0; if_ce = 0; if_pc = 0; rom_rdata = 0; last_pc = 0; redir = 0;
    m_inf = 0; m_req = 0; m_pc = 0; m_inst = 0; m_val = 0; m_fetch = 0; m_bub = 0;
    @(negedge clk);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    chk("latency_pc", id_pc, 32'h0);
    chk("latency_inst", id_inst, 32'h20000000);
    chk("latency_valid", {31'b0, id_valid}, 32'h1);
    repeat (6) step(0, 0, 0, 1, 0);
    repeat (5) step(0, 0, 6'b000110, 1, 0);
    chk("hold_full", {31'b0, fq_stall}, 32'h1);
    step(0, 0, 6'b000010, 1, 0);
    chk("bubble_valid", {31'b0, id_valid}, 32'h0);
    chk("bubble_pc", id_pc, 32'h0);
    repeat (3) step(0, 0, 0, 1, 0);
    repeat (1) step(0, 0, 6'b000110, 1, 0);
    redir = 32'h1000;
    step(0, 1, 0, 1, 0);
    chk("flush_valid", {31'b0, id_valid}, 32'h0);
    step(0, 0, 0, 1, 1);
    repeat (4) begin
      step(0, 0, 0, 1, 0);
      chk("no_deadbeef", {31'b0, id_inst == 32'hDEADBEEF}, 32'h0);
    end
    repeat (2) step(0, 0, 6'b000110, 1, 0);
    step(1, 0, 0, 1, 0);
    chk("rst_valid", {31'b0, id_valid}, 32'h0);
    repeat (5) step(0, 0, 0, 1, 0);
    repeat (600) begin
      logic [5:0] s;
      s = 0;
      s[0] = ($urandom_range(0, 9) < 2);
      s[1] = ($urandom_range(0, 9) < 3);
      s[2] = ($urandom_range(0, 1) == 1);
      s[5:3] = 3'($urandom);
      redir = $urandom & 32'hFFFF_FFFC;
      step($urandom_range(0, 99) == 0, $urandom_range(0, 29) == 0, s, $urandom_range(0, 9) != 0, 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
